sparse_row_sum_scheduler: RTL and testbench
===========================================

Name: sparse_row_sum_scheduler

Overview:
- Reduces up to 64 CIM row outputs (4 bits each) to one 10-bit column sum.
- Skips rows whose sparsity mask bit is 0.
- Time-multiplexes a small pool of NUM_ADD shared fourBitAdder instances instead of a full 32-adder tree.
- Sits between the CIM array readout and the column accumulator, using valid/ready handshakes on both sides.

Parameters:
- ROWS, 64, number of rows per operation.
- DATA_W, 4, bits per row value.
- NUM_ADD, 4, shared fourBitAdder instances; up to 2*NUM_ADD rows consumed per SCAN cycle.
- ACC_W, 10, sum width; must satisfy 2^ACC_W > ROWS*(2^DATA_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_mask  in  ROWS  row-active mask; bit i=1 means row i participates.
- in_data  in  ROWS*DATA_W  packed rows; row i is in_data[i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  sum of active rows.
- out_count  out  7  popcount of the accepted mask.
- out_cycles  out  6  number of SCAN cycles spent.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE. in_ready=1, out_valid=0, out_sum=0, out_count=0, out_cycles=0, busy=0. Internal mask and data registers cleared.
- Reset mid-operation aborts the operation, discards the result and returns to IDLE. No partial result is emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_mask and in_data, clear accumulator and counters, go to SCAN.
  - SCAN: in_ready=0. Each cycle:
    - Select the lowest-index set bits of the pending mask, up to 2*NUM_ADD of them.
    - Pair selected rows in index order: (1st,2nd), (3rd,4th), and so on. An unfilled slot feeds 0.
    - Each pair goes through one fourBitAdder (5-bit result).
    - Zero-extend the NUM_ADD results and add them into the accumulator (ACC_W bits, no saturation needed by construction).
    - Clear the selected bits and increment out_cycles.
    - If the pending mask after clearing is 0, go to DONE.
  - DONE: out_valid=1; out_sum, out_count and out_cycles held stable. On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
- Zero mask: exactly one SCAN cycle adds 0, then DONE with out_sum=0, out_count=0, out_cycles=1.
- Latency: out_valid rises k+1 edges after the accept edge, where k = max(1, ceil(popcount/(2*NUM_ADD))). Maximum k=8 for the full mask with defaults.
- Back-to-back: a new request can be accepted no earlier than the cycle after the DONE handshake (in_ready=1 only in IDLE). There is no overlap of operations.
- Back-pressure: out_ready=0 holds DONE indefinitely with outputs stable. in_valid is ignored while busy.
- in_data of masked-off rows never affects out_sum.

Decomposition:
- Package sparse_cim_pkg holds:
  - ROWS, DATA_W, ACC_W constants.
  - The state enum (IDLE, SCAN, DONE).
  - The popcount width constant.
- Sub-module sparse_row_picker (combinational): takes the pending mask and returns up to 2*NUM_ADD selected row indices, per-slot valid bits, and the cleared mask.
- The adders are existing fourBitAdder instances generated NUM_ADD times.
- The top level holds the FSM, the accumulator, the counters and the handshake.

Test Plan:
- Reset, then mask=0 -> out_valid 2 edges after accept; out_sum=0, out_count=0, out_cycles=1.
- Full mask, all rows=4'hF -> out_sum=960, out_count=64, out_cycles=8, latency 9 edges.
- mask=64'h1 with row0=7, all other rows=4'hF -> out_sum=7, out_count=1, out_cycles=1 (checks that masked data is ignored).
- mask=64'h8000_0000_0000_0155, row i = i mod 16 -> active rows {0,2,4,6,8,63}: out_sum=0+2+4+6+8+15=35, out_count=6, out_cycles=1 (odd pairing with zero slot).
- Full mask, hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 while in_valid=1. Release out_ready -> next request accepted the following cycle.
- Assert rst_n=0 during SCAN of the full-mask case -> immediate IDLE, out_valid=0. A subsequent request (mask=64'h3, rows 9 and 6) gives out_sum=15 with no carryover.

Source files
------------

// File: rtl/sparse_cim_pkg.sv
// Shared constants, FSM state type and helpers for the sparse row-sum scheduler.
// Contents:
//   ROWS, DATA_W, ACC_W   - geometry of one reduction
//   IDX_W, CNT_W, CYC_W   - row index, popcount and SCAN-cycle counter widths
//   state_e               - scheduler FSM states
//   popcount()            - number of set bits in a row mask
package sparse_cim_pkg;

    localparam int unsigned ROWS   = 64;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ACC_W  = 10;
    localparam int unsigned IDX_W  = $clog2(ROWS);
    localparam int unsigned CNT_W  = $clog2(ROWS + 1);
    localparam int unsigned CYC_W  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [ROWS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fourBitAdder.sv
// Shared 4-bit adder cell: sum_o = a_i + b_i with carry in bit 4.
// Ports:
//   a_i, b_i - 4-bit operands
//   sum_o    - 5-bit result
module fourBitAdder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [4:0] sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/sparse_row_picker.sv
// Combinational picker: selects the lowest-index set bits of the pending mask.
// Ports:
//   mask_i - pending row mask
//   idx_o  - selected row indices, slot 0 holds the lowest index
//   vld_o  - per-slot valid; unfilled slots have vld_o=0 and idx_o=0
//   mask_o - pending mask with the selected bits cleared
module sparse_row_picker
    import sparse_cim_pkg::*;
#(
    parameter int unsigned Slots = 8
) (
    input  logic [ROWS-1:0]             mask_i,
    output logic [Slots-1:0][IDX_W-1:0] idx_o,
    output logic [Slots-1:0]            vld_o,
    output logic [ROWS-1:0]             mask_o
);

    logic [ROWS-1:0] rem;

    always_comb begin
        rem   = mask_i;
        idx_o = '0;
        vld_o = '0;
        for (int s = 0; s < int'(Slots); s++) begin
            // Descending scan so the lowest set bit is the last one written.
            for (int i = int'(ROWS) - 1; i >= 0; i--) begin
                if (rem[i]) begin
                    idx_o[s] = IDX_W'(i);
                end
            end
            vld_o[s] = |rem;
            // Clear the lowest set bit.
            rem = rem & (rem - ROWS'(1));
        end
        mask_o = rem;
    end

endmodule

// File: rtl/sparse_row_sum_scheduler.sv
// Sparse row-sum scheduler: sums the masked-in 4-bit rows of a CIM readout into one
// column sum, using a small pool of shared fourBitAdder cells over several SCAN cycles.
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   - request handshake; in_mask_i, in_data_i are the payload
//   out_valid_o / out_ready_i - result handshake; out_sum_o, out_count_o, out_cycles_o
//   busy_o                    - high whenever not idle
module sparse_row_sum_scheduler
    import sparse_cim_pkg::*;
#(
    parameter int unsigned NumAdd = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [ROWS-1:0]        in_mask_i,
    input  logic [ROWS*DATA_W-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ACC_W-1:0]       out_sum_o,
    output logic [CNT_W-1:0]       out_count_o,
    output logic [CYC_W-1:0]       out_cycles_o,
    output logic                   busy_o
);

    localparam int unsigned Slots = 2 * NumAdd;

    state_e                   state_q, state_d;
    logic [ROWS-1:0]          mask_q, mask_d;
    logic [ROWS*DATA_W-1:0]   data_q, data_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CYC_W-1:0]         cyc_q, cyc_d;

    logic [Slots-1:0][IDX_W-1:0] pick_idx;
    logic [Slots-1:0]            pick_vld;
    logic [ROWS-1:0]             mask_left;
    logic [NumAdd-1:0][4:0]      psum;
    logic [ACC_W-1:0]            step_sum;

    sparse_row_picker #(
        .Slots (Slots)
    ) u_picker (
        .mask_i (mask_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld),
        .mask_o (mask_left)
    );

    // Slot pairs (0,1), (2,3), ... share one adder; empty slots contribute 0.
    for (genvar j = 0; j < int'(NumAdd); j++) begin : g_add
        logic [DATA_W-1:0] op_a, op_b;
        assign op_a = pick_vld[2*j]   ? data_q[pick_idx[2*j]*DATA_W +: DATA_W]   : '0;
        assign op_b = pick_vld[2*j+1] ? data_q[pick_idx[2*j+1]*DATA_W +: DATA_W] : '0;
        fourBitAdder u_add (
            .a_i   (op_a),
            .b_i   (op_b),
            .sum_o (psum[j])
        );
    end

    always_comb begin
        step_sum = '0;
        for (int j = 0; j < int'(NumAdd); j++) begin
            step_sum = step_sum + ACC_W'(psum[j]);
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        data_d      = data_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mask_d  = in_mask_i;
                    data_d  = in_data_i;
                    acc_d   = '0;
                    cnt_d   = popcount(in_mask_i);
                    cyc_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                // A zero mask still spends one SCAN cycle adding 0.
                acc_d  = acc_q + step_sum;
                cyc_d  = cyc_q + CYC_W'(1);
                mask_d = mask_left;
                if (mask_left == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mask_q  <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign out_sum_o    = acc_q;
    assign out_count_o  = cnt_q;
    assign out_cycles_o = cyc_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sparse_row_sum_scheduler.sv
// Self-checking bench for sparse_row_sum_scheduler: directed table, random ops against a
// row-by-row reference sum, back-pressure and mid-operation reset sequences.
module tb_sparse_row_sum_scheduler;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [63:0]  in_mask_i;
    logic [255:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [9:0]   out_sum_o;
    logic [6:0]   out_count_o;
    logic [5:0]   out_cycles_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    sparse_row_sum_scheduler dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_mask_i    (in_mask_i),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_sum_o    (out_sum_o),
        .out_count_o  (out_count_o),
        .out_cycles_o (out_cycles_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        string        name;
        logic [63:0]  mask;
        logic [255:0] data;
        int           sum;
        int           cnt;
        int           cyc;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sum every active row, count them, and derive the SCAN cycles from the
    // number of rows that 2*NUM_ADD = 8 slots can consume per cycle.
    function automatic void model(input logic [63:0] m, input logic [255:0] d,
                                  output int s, output int c, output int cy);
        s = 0;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) begin
                s += int'(d[i*4 +: 4]);
                c++;
            end
        end
        cy = (c == 0) ? 1 : (c + 7) / 8;
    endfunction

    // Latency counts rising edges from the accept edge (inclusive) to the first edge
    // after which out_valid is seen: k SCAN edges plus the accept edge.
    task automatic run_op(input string name, input logic [63:0] m, input logic [255:0] d,
                          input int es, input int ec, input int ecy);
        int lat;
        @(negedge clk_i);
        chk({name, " in_ready"}, 64'(in_ready_o), 64'd1);
        in_mask_i  = m;
        in_data_i  = d;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 40) begin
            @(posedge clk_i);
            #1 lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(ecy + 1));
        chk({name, " sum"}, 64'(out_sum_o), 64'(es));
        chk({name, " count"}, 64'(out_count_o), 64'(ec));
        chk({name, " cycles"}, 64'(out_cycles_o), 64'(ecy));
        @(posedge clk_i);
        #1 chk({name, " valid drop"}, 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        logic [255:0] d;
        logic [63:0]  m;
        int           es, ec, ecy, n;

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_mask_i   = '0;
        in_data_i   = '0;
        out_ready_i = 1'b1;

        // Directed table.
        tbl[0] = '{"zero", 64'h0, {64{4'hA}}, 0, 0, 1};
        tbl[1] = '{"full", {64{1'b1}}, {64{4'hF}}, 960, 64, 8};
        d = {64{4'hF}};
        d[3:0] = 4'h7;
        tbl[2] = '{"single", 64'h1, d, 7, 1, 1};
        for (int i = 0; i < 64; i++) d[i*4 +: 4] = 4'(i % 16);
        tbl[3] = '{"odd", 64'h8000_0000_0000_0155, d, 35, 6, 1};

        #12;
        chk("rst in_ready", 64'(in_ready_o), 64'd1);
        chk("rst out_valid", 64'(out_valid_o), 64'd0);
        chk("rst sum", 64'(out_sum_o), 64'd0);
        chk("rst count", 64'(out_count_o), 64'd0);
        chk("rst cycles", 64'(out_cycles_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run_op(tbl[t].name, tbl[t].mask, tbl[t].data, tbl[t].sum, tbl[t].cnt, tbl[t].cyc);
        end

        // Random ops with varied mask density.
        for (int r = 0; r < 30; r++) begin
            m = {$urandom, $urandom};
            case (r % 4)
                0: m = m & {$urandom, $urandom} & {$urandom, $urandom};
                1: m = m | {$urandom, $urandom};
                2: m = 64'(1) << $urandom_range(63, 0);
                default: ;
            endcase
            for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
            model(m, d, es, ec, ecy);
            run_op($sformatf("rand%0d", r), m, d, es, ec, ecy);
        end

        // Back-pressure: full mask, hold DONE for 5 cycles while a new request waits.
        out_ready_i = 1'b0;
        @(negedge clk_i);
        in_mask_i  = '1;
        in_data_i  = {64{4'hF}};
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_mask_i = 64'h3;
        d = '0;
        d[3:0] = 4'h9;
        d[7:4] = 4'h6;
        in_data_i = d;
        n = 0;
        while (!out_valid_o && n < 40) begin
            @(posedge clk_i);
            #1 n++;
        end
        chk("bp reach done", 64'(out_valid_o), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            #1;
            chk("bp valid", 64'(out_valid_o), 64'd1);
            chk("bp in_ready", 64'(in_ready_o), 64'd0);
            chk("bp sum", 64'(out_sum_o), 64'd960);
            chk("bp count", 64'(out_count_o), 64'd64);
            chk("bp cycles", 64'(out_cycles_o), 64'd8);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp release valid", 64'(out_valid_o), 64'd0);
        chk("bp release in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        chk("bp next accepted", 64'(busy_o), 64'd1);
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 40) begin
            @(posedge clk_i);
            #1 n++;
        end
        chk("bp next sum", 64'(out_sum_o), 64'd15);
        @(posedge clk_i);
        #1;

        // Reset during SCAN of a full-mask op.
        @(negedge clk_i);
        in_mask_i  = '1;
        in_data_i  = {64{4'hF}};
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("mid busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid_o), 64'd0);
        chk("abort in_ready", 64'(in_ready_o), 64'd1);
        chk("abort busy", 64'(busy_o), 64'd0);
        chk("abort sum", 64'(out_sum_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op("post-reset", 64'h3, d, 15, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
